vproc_bus_arbiter: RTL

Round-robin arbiter that shares one VProc-style memory-mapped slave between NUM_REQ VProc node bus masters. Each requester presents the standard VProc bus signals: Addr, WE, RD, DataOut, Burst. The arbiter grants one requester at a time and holds the grant for the whole burst. It muxes the granted requester onto the slave port and routes acknowledges back to that requester only. A watchdog synthesises an acknowledge if the slave never responds, so a hung slave cannot deadlock the simulation.

---
 rtl/vproc_bus_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one VProc memory-mapped slave among NUM_REQ masters.
// Grant is held for a whole burst; a watchdog synthesises an ack on a hung slave.
module vproc_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [32*NUM_REQ-1:0]   ReqAddr,
    input  logic [NUM_REQ-1:0]      ReqWE,
    input  logic [NUM_REQ-1:0]      ReqRD,
    input  logic [32*NUM_REQ-1:0]   ReqDataOut,
    input  logic [12*NUM_REQ-1:0]   ReqBurst,
    output logic [31:0]             ReqDataIn,
    output logic [NUM_REQ-1:0]      ReqWRAck,
    output logic [NUM_REQ-1:0]      ReqRDAck,
    output logic [NUM_REQ-1:0]      Grant,
    output logic [31:0]             Addr,
    output logic                    WE,
    output logic                    RD,
    output logic [31:0]             DataOut,
    input  logic [31:0]             DataIn,
    input  logic                    WRAck,
    input  logic                    RDAck,
    output logic                    TimeoutErr
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t               state, state_nx;
    logic [NUM_REQ-1:0]   grant_nx;
    logic [IW-1:0]        last, last_nx;
    logic [12:0]          beat_cnt, beat_nx;
    logic [TW-1:0]        timer, timer_nx;

    logic [NUM_REQ-1:0]   req;
    logic [IW-1:0]        winner, hi_w, lo_w;
    logic                 hi_found, found;
    logic [11:0]          win_burst;
    logic                 own, real_ack, fire, beat_ack;

    assign req = ReqWE | ReqRD;
    assign own = (state == OWN);

    // Rotating priority: lowest requester above Last, else lowest overall.
    always_comb begin
        hi_w     = '0;
        lo_w     = '0;
        hi_found = 1'b0;
        found    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_w  = IW'(i);
                found = 1'b1;
                if (i > int'(last)) begin
                    hi_w     = IW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        winner = hi_found ? hi_w : lo_w;
    end

    always_comb begin
        win_burst = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IW'(i)) win_burst = ReqBurst[12*i +: 12];
        end
    end

    assign real_ack = (WE & WRAck) | (RD & RDAck);
    assign fire     = own & (WE | RD) & (timer == TLAST) & ~real_ack;
    assign beat_ack = real_ack | fire;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            Grant      <= '0;
            last       <= IW'(NUM_REQ - 1);
            beat_cnt   <= '0;
            timer      <= '0;
            TimeoutErr <= 1'b0;
        end else begin
            state      <= state_nx;
            Grant      <= grant_nx;
            last       <= last_nx;
            beat_cnt   <= beat_nx;
            timer      <= timer_nx;
            TimeoutErr <= fire;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        grant_nx = Grant;
        last_nx  = last;
        beat_nx  = beat_cnt;
        timer_nx = timer;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nx = OWN;
                    grant_nx = NUM_REQ'(1) << winner;
                    last_nx  = winner;
                    beat_nx  = (win_burst == 12'd0) ? 13'd1 : {1'b0, win_burst};
                    timer_nx = '0;
                end
            end
            OWN: begin
                if (beat_ack) begin
                    timer_nx = '0;
                    beat_nx  = beat_cnt - 13'd1;
                    if (beat_cnt == 13'd1) begin
                        state_nx = IDLE;
                        grant_nx = '0;
                    end
                end else if (WE | RD) begin
                    timer_nx = timer + TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: Grant is one-hot only in OWN, so it doubles as the mux select.
    always_comb begin
        Addr    = '0;
        DataOut = '0;
        WE      = 1'b0;
        RD      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (Grant[i]) begin
                Addr    = ReqAddr[32*i +: 32];
                DataOut = ReqDataOut[32*i +: 32];
                WE      = ReqWE[i];
                RD      = ReqRD[i];
            end
        end
        ReqWRAck  = Grant & {NUM_REQ{WE & (WRAck | fire)}};
        ReqRDAck  = Grant & {NUM_REQ{RD & (RDAck | fire)}};
        ReqDataIn = fire ? 32'hDEADBEEF : DataIn;
    end

endmodule
